// File: rtl/roi_bram_loader.sv
// Drains one WIDTH x HEIGHT raster frame from a show-ahead FIFO and packs one channel of the
// pixels inside a run-time ROI into a BRAM. Optional macro ROI_DECIMATE_EN enables 2:1 subsampling.
module roi_bram_loader #(
    parameter int unsigned WIDTH        = 1280,
    parameter int unsigned HEIGHT       = 720,
    parameter int unsigned DIN_W        = 24,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CH_LSB       = 0,
    parameter int unsigned MAX_ROI_SIZE = 245760
) (
    input  logic                              clock,
    input  logic                              reset_n,
    output logic                              in_rd_en,
    input  logic                              in_empty,
    input  logic [DIN_W-1:0]                  in_dout,
    input  logic [$clog2(WIDTH+1)-1:0]        roi_x0,
    input  logic [$clog2(WIDTH+1)-1:0]        roi_x1,
    input  logic [$clog2(HEIGHT+1)-1:0]       roi_y0,
    input  logic [$clog2(HEIGHT+1)-1:0]       roi_y1,
    output logic                              bram_out_wr_en,
    output logic [$clog2(MAX_ROI_SIZE)-1:0]   bram_out_wr_addr,
    output logic [DATA_W-1:0]                 bram_out_wr_data,
    output logic                              busy,
    output logic                              roi_err,
    output logic                              frame_done
);

    localparam int unsigned ADDR_W = $clog2(MAX_ROI_SIZE);
    localparam int unsigned XW     = $clog2(WIDTH + 1);
    localparam int unsigned YW     = $clog2(HEIGHT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    logic [XW-1:0]     sx0;
    logic [XW-1:0]     sx1;
    logic [YW-1:0]     sy0;
    logic [YW-1:0]     sy1;
    logic              roi_ok;

    logic              pop;
    logic              last_px;
    logic              in_roi;
    logic              roi_ok_c;
    logic [XW-1:0]     roi_w;
    logic [YW-1:0]     roi_h;
    logic [31:0]       roi_area;
    logic              unused_in_bits;

    assign unused_in_bits = ^in_dout;

    // ROI validity from the live pins; only sampled at the frame-start latch
    always_comb begin
        roi_w = roi_x1 - roi_x0;
        roi_h = roi_y1 - roi_y0;
`ifdef ROI_DECIMATE_EN
        roi_area = ((32'(roi_w) + 32'd1) >> 1) * ((32'(roi_h) + 32'd1) >> 1);
`else
        roi_area = 32'(roi_w) * 32'(roi_h);
`endif
        roi_ok_c = (roi_x0 < roi_x1) && (roi_y0 < roi_y1)
                && (32'(roi_x1) <= WIDTH) && (32'(roi_y1) <= HEIGHT)
                && (roi_area <= MAX_ROI_SIZE);
    end

    assign last_px = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));

    // Pixel selection against the frame's shadow ROI
    always_comb begin
        in_roi = roi_ok && (x >= sx0) && (x < sx1) && (y >= sy0) && (y < sy1);
`ifdef ROI_DECIMATE_EN
        in_roi = in_roi && !(x[0] ^ sx0[0]) && !(y[0] ^ sy0[0]);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_rd_en  = 1'b0;
        case (state)
            S_IDLE: if (!in_empty) state_nxt = S_LOAD;
            S_LOAD: begin
                in_rd_en = !in_empty;
                if (!in_empty && last_px) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign pop = in_rd_en;

    // Raster counters, shadow ROI and registered BRAM port
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x                <= '0;
            y                <= '0;
            addr             <= '0;
            sx0              <= '0;
            sx1              <= '0;
            sy0              <= '0;
            sy1              <= '0;
            roi_ok           <= 1'b0;
            bram_out_wr_en   <= 1'b0;
            bram_out_wr_addr <= '0;
            bram_out_wr_data <= '0;
            busy             <= 1'b0;
            roi_err          <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            bram_out_wr_en <= 1'b0;
            frame_done     <= 1'b0;
            busy           <= (state_nxt == S_LOAD) || (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (!in_empty) begin
                        sx0     <= roi_x0;
                        sx1     <= roi_x1;
                        sy0     <= roi_y0;
                        sy1     <= roi_y1;
                        roi_ok  <= roi_ok_c;
                        roi_err <= !roi_ok_c;
                        x       <= '0;
                        y       <= '0;
                        addr    <= '0;
                    end
                end
                S_LOAD: begin
                    if (pop) begin
                        bram_out_wr_en   <= in_roi;
                        bram_out_wr_addr <= addr;
                        bram_out_wr_data <= in_dout[CH_LSB +: DATA_W];
                        frame_done       <= last_px;
                        if (in_roi) addr <= addr + ADDR_W'(1);
                        if (x == XW'(WIDTH - 1)) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                S_DONE: ;
                default: begin
                    bram_out_wr_addr <= '0;
                    bram_out_wr_data <= '0;
                    roi_err          <= 1'b0;
                    roi_ok           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_roi_bram_loader.sv
// Bench for roi_bram_loader: queue-based FIFO, pixel-index ROI model checked every cycle,
// plus literal write lists for the directed frames.
module tb_roi_bram_loader;

    localparam int W = 8;
    localparam int H = 4;
    localparam int MAXS = 16;

    typedef struct {
        int x0;
        int x1;
        int y0;
        int y1;
    } roi_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_rd_en;
    logic        in_empty = 1'b1;
    logic [23:0] in_dout = '0;
    logic [3:0]  roi_x0 = '0;
    logic [3:0]  roi_x1 = '0;
    logic [2:0]  roi_y0 = '0;
    logic [2:0]  roi_y1 = '0;
    logic        bram_out_wr_en;
    logic [3:0]  bram_out_wr_addr;
    logic [7:0]  bram_out_wr_data;
    logic        busy;
    logic        roi_err;
    logic        frame_done;

    roi_bram_loader #(
        .WIDTH(W), .HEIGHT(H), .DIN_W(24), .DATA_W(8), .CH_LSB(8), .MAX_ROI_SIZE(MAXS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .in_rd_en(in_rd_en), .in_empty(in_empty),
        .in_dout(in_dout), .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
        .bram_out_wr_en(bram_out_wr_en), .bram_out_wr_addr(bram_out_wr_addr),
        .bram_out_wr_data(bram_out_wr_data), .busy(busy), .roi_err(roi_err),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] fifo_q[$];
    roi_t       roi_q[$];
    bit         stall_en = 0;
    bit         stall_phase = 0;

    // model state
    bit   pop_now = 0;
    int   pix_idx = 0;
    roi_t m_roi;
    bit   m_valid = 0;
    bit   exp_en = 0;
    int   exp_addr = 0;
    int   exp_data = 0;
    bit   exp_done = 0;

    int done_seen = 0;
    int frame_pops = 0;
    int wr_cnt = 0;
    int log_addr[64];
    int log_data[64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) $display("FAIL %s: actual %0d required %0d", name, act, req);
        else n_pass++;
    endtask

    function automatic bit roi_valid(input roi_t r);
        int w = r.x1 - r.x0;
        int h = r.y1 - r.y0;
        if (r.x0 >= r.x1 || r.y0 >= r.y1 || r.x1 > W || r.y1 > H) return 1'b0;
`ifdef ROI_DECIMATE_EN
        return ((w + 1) / 2) * ((h + 1) / 2) <= MAXS;
`else
        return w * h <= MAXS;
`endif
    endfunction

    // Where (if anywhere) raster pixel p must land in the packed BRAM
    function automatic void model_hit(input int p, input roi_t r, input bit v,
                                      output bit hit, output int a);
        int px = p % W;
        int py = p / W;
        int w  = r.x1 - r.x0;
        hit = 1'b0;
        a   = 0;
        if (v && px >= r.x0 && px < r.x1 && py >= r.y0 && py < r.y1) begin
`ifdef ROI_DECIMATE_EN
            if ((px - r.x0) % 2 == 0 && (py - r.y0) % 2 == 0) begin
                hit = 1'b1;
                a   = ((py - r.y0) / 2) * ((w + 1) / 2) + (px - r.x0) / 2;
            end
`else
            hit = 1'b1;
            a   = (py - r.y0) * w + (px - r.x0);
`endif
        end
    endfunction

    // Compare process: checks outputs for the previous edge, then predicts the next one
    always @(negedge clock) begin
        if (!reset_n) begin
            chk("reset_outputs", 32'({bram_out_wr_en, bram_out_wr_addr, bram_out_wr_data,
                                      busy, roi_err, frame_done, in_rd_en}), 32'd0);
            exp_en   = 0;
            exp_done = 0;
            pop_now  = 0;
            pix_idx  = 0;
        end else begin
            chk("wr_en", 32'(bram_out_wr_en), 32'(exp_en));
            if (exp_en) begin
                chk("wr_addr", 32'(bram_out_wr_addr), 32'(exp_addr));
                chk("wr_data", 32'(bram_out_wr_data), 32'(exp_data));
            end
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            if (exp_done) begin
                chk("roi_err", 32'(roi_err), 32'(!m_valid));
                chk("busy_done", 32'(busy), 32'd1);
            end
            if (in_empty) chk("rd_en_while_empty", 32'(in_rd_en), 32'd0);
            if (bram_out_wr_en && wr_cnt < 64) begin
                log_addr[wr_cnt] = int'(bram_out_wr_addr);
                log_data[wr_cnt] = int'(bram_out_wr_data);
                wr_cnt++;
            end
            if (frame_done) done_seen++;

            pop_now  = in_rd_en && !in_empty;
            exp_en   = 0;
            exp_done = 0;
            if (pop_now) begin
                if (pix_idx == 0) begin
                    chk("frame_queued", 32'(roi_q.size() != 0), 32'd1);
                    if (roi_q.size() != 0) begin
                        m_roi   = roi_q.pop_front();
                        m_valid = roi_valid(m_roi);
                    end
                end
                model_hit(pix_idx, m_roi, m_valid, exp_en, exp_addr);
                exp_data = int'(fifo_q[0]);
                exp_done = (pix_idx == W * H - 1);
                pix_idx  = (pix_idx + 1) % (W * H);
            end
        end
    end

    task automatic drive_inputs();
        in_empty = (fifo_q.size() == 0) || (stall_en && stall_phase);
        in_dout  = (fifo_q.size() != 0) ? {8'h00, fifo_q[0], 8'h00} : 24'h0;
    endtask

    task automatic set_pins(input roi_t r);
        roi_x0 = 4'(r.x0);
        roi_x1 = 4'(r.x1);
        roi_y0 = 3'(r.y0);
        roi_y1 = 3'(r.y1);
    endtask

    task automatic push_frame(input roi_t r);
        for (int i = 0; i < W * H; i++) fifo_q.push_back(8'(i));
        roi_q.push_back(r);
    endtask

    task automatic run(input string name, input int n_frames, input int chg_at,
                       input roi_t chg_roi, input int abort_at);
        int cyc = 0;
        done_seen  = 0;
        frame_pops = 0;
        drive_inputs();
        while (cyc < 600) begin
            @(posedge clock);
            #1;
            if (pop_now) begin
                void'(fifo_q.pop_front());
                frame_pops++;
            end
            if (chg_at >= 0 && frame_pops == chg_at) set_pins(chg_roi);
            if (abort_at >= 0 && frame_pops == abort_at) begin
                reset_n = 1'b0;
                return;
            end
            stall_phase = !stall_phase;
            drive_inputs();
            if (done_seen >= n_frames) break;
            cyc++;
        end
        if (done_seen < n_frames) chk({name, "_timeout"}, 32'(done_seen), 32'(n_frames));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        roi_t r1;
        roi_t r2;
        roi_t rnone;
        int exp1[8];
        exp1  = '{10, 11, 12, 13, 18, 19, 20, 21};
        r1    = '{x0: 2, x1: 6, y0: 1, y1: 3};
        r2    = '{x0: 1, x1: 4, y0: 2, y1: 4};
        rnone = '{x0: 0, x1: 0, y0: 0, y1: 0};

        idle(3);
        reset_n = 1'b1;
        idle(2);
        chk("busy_after_reset", 32'(busy), 32'd0);

        // 1: continuous FIFO
        set_pins(r1);
        push_frame(r1);
        wr_cnt = 0;
        run("t1", 1, -1, rnone, -1);
        idle(2);
        chk("t1_pops", 32'(frame_pops), 32'd32);
        chk("t1_writes", 32'(wr_cnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_addr", 32'(log_addr[i]), 32'(i));
            chk("t1_data", 32'(log_data[i]), 32'(exp1[i]));
        end
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // 2: in_empty toggling
        stall_en = 1;
        push_frame(r1);
        wr_cnt = 0;
        run("t2", 1, -1, rnone, -1);
        stall_en = 0;
        idle(2);
        chk("t2_writes", 32'(wr_cnt), 32'd8);
        for (int i = 0; i < 8; i++) chk("t2_data", 32'(log_data[i]), 32'(exp1[i]));

        // 3: x0 >= x1
        r2 = '{x0: 5, x1: 3, y0: 0, y1: 4};
        set_pins(r2);
        push_frame(r2);
        wr_cnt = 0;
        run("t3", 1, -1, rnone, -1);
        idle(2);
        chk("t3_pops", 32'(frame_pops), 32'd32);
        chk("t3_writes", 32'(wr_cnt), 32'd0);
        chk("t3_err_sticky", 32'(roi_err), 32'd1);

        // 5: back-to-back, pins changed mid-frame 1
        r2 = '{x0: 1, x1: 4, y0: 2, y1: 4};
        set_pins(r1);
        push_frame(r1);
        push_frame(r2);
        wr_cnt = 0;
        run("t5", 2, 10, r2, -1);
        idle(2);
        chk("t5_pops", 32'(frame_pops), 32'd64);
        chk("t5_writes", 32'(wr_cnt), 32'd14);
        chk("t5_f1_last_data", 32'(log_data[7]), 32'd21);
        chk("t5_f2_first_addr", 32'(log_addr[8]), 32'd0);
        chk("t5_f2_first_data", 32'(log_data[8]), 32'd17);
        chk("t5_f2_last_addr", 32'(log_addr[13]), 32'd5);
        chk("t5_f2_last_data", 32'(log_data[13]), 32'd27);
        chk("t5_err_cleared", 32'(roi_err), 32'd0);

        // 4: full frame, too large unless decimated
        r2 = '{x0: 0, x1: 8, y0: 0, y1: 4};
        set_pins(r2);
        push_frame(r2);
        wr_cnt = 0;
        run("t4", 1, -1, rnone, -1);
        idle(2);
`ifdef ROI_DECIMATE_EN
        chk("t4_writes", 32'(wr_cnt), 32'd8);
        chk("t4_err", 32'(roi_err), 32'd0);
        chk("t4_data4", 32'(log_data[4]), 32'd16);
        chk("t4_addr7", 32'(log_addr[7]), 32'd7);
        chk("t4_data7", 32'(log_data[7]), 32'd22);
`else
        chk("t4_writes", 32'(wr_cnt), 32'd0);
        chk("t4_err", 32'(roi_err), 32'd1);
`endif

        // 6: reset at pixel 13, then a fresh frame
        set_pins(r1);
        push_frame(r1);
        run("t6a", 1, -1, rnone, 13);
        @(negedge clock);
        fifo_q.delete();
        roi_q.delete();
        drive_inputs();
        idle(2);
        reset_n = 1'b1;
        r2 = '{x0: 0, x1: 4, y0: 0, y1: 4};
        set_pins(r2);
        push_frame(r2);
        wr_cnt = 0;
        run("t6b", 1, -1, rnone, -1);
        idle(2);
        chk("t6_pops", 32'(frame_pops), 32'd32);
        chk("t6_writes", 32'(wr_cnt), 32'd16);
        chk("t6_first_addr", 32'(log_addr[0]), 32'd0);
        chk("t6_first_data", 32'(log_data[0]), 32'd0);
        chk("t6_last_addr", 32'(log_addr[15]), 32'd15);
        chk("t6_last_data", 32'(log_data[15]), 32'd27);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

endmodule
